// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential wide ALU: FSM states,
// opcode encodings and slice-count helper.
package seq_alu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      MUL,
      DONE
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MUL = 1'b1;

   function automatic int calc_slices(input int width, input int word);
      return width / word;
   endfunction

endpackage

// File: rtl/alu_word_adder.sv
// One WORD-bit ripple slice with carry in/out; the wide add walks these
// slices one per cycle.
module alu_word_adder #(
   parameter int WORD = 32
) (
   input  logic [WORD-1:0] a,
   input  logic [WORD-1:0] b,
   input  logic            cin,
   output logic [WORD-1:0] sum,
   output logic            cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WORD{1'b0}}, cin};

endmodule

// File: rtl/seq_wide_alu.sv
// Sequential wide unsigned ALU: slice-serial add (WORD bits per cycle) or
// radix-2 shift-add multiply (one bit per cycle), with a valid/ready result.
module seq_wide_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 512,
   parameter int WORD  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in1,
   input  logic [WIDTH-1:0]   in2,
   input  logic               op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out,
   output logic               Z
);

   localparam int N     = calc_slices(WIDTH, WORD);
   localparam int CNT_W = $clog2((N > WIDTH) ? N : WIDTH) + 1;
   localparam logic [CNT_W-1:0] ADD_LAST = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);

   if (WIDTH % WORD != 0) begin : g_width_check
      $error("seq_wide_alu: WIDTH must be a multiple of WORD");
   end

   state_t               state;
   logic [WIDTH-1:0]     a_reg;
   logic [WIDTH-1:0]     b_reg;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_next;
   logic                 carry;
   logic [CNT_W-1:0]     cnt;
   logic                 last;
   logic [WORD-1:0]      slice_sum;
   logic                 slice_cout;
   logic [WIDTH:0]       mul_sum;

   alu_word_adder #(.WORD(WORD)) u_slice (
      .a    (a_reg[WORD-1:0]),
      .b    (b_reg[WORD-1:0]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Multiply accumulates into the upper half, then the whole product shifts right.
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_reg[0] ? {1'b0, a_reg} : '0);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      acc_next = acc;
      last     = 1'b0;
      case (state)
         ADD: begin
            // Sum slices enter at the top of the low half; bit WIDTH tracks the latest carry.
            acc_next = {{(WIDTH-1){1'b0}}, slice_cout, slice_sum, acc[WIDTH-1:WORD]};
            last     = (cnt == ADD_LAST);
         end
         MUL: begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
            last     = (cnt == MUL_LAST);
         end
         default: ;
      endcase
   end

   // NOTE: all state, datapath and result registers are cleared by reset so an aborted operation leaves no trace.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         out   <= '0;
         Z     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= in1;
                  b_reg <= in2;
                  acc   <= '0;
                  carry <= 1'b0;
                  cnt   <= '0;
                  state <= (op == OP_MUL) ? MUL : ADD;
               end
            end
            ADD: begin
               acc   <= acc_next;
               carry <= slice_cout;
               a_reg <= a_reg >> WORD;
               b_reg <= b_reg >> WORD;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  out   <= acc_next;
                  Z     <= (acc_next == '0);
                  state <= DONE;
               end
            end
            MUL: begin
               acc   <= acc_next;
               b_reg <= b_reg >> 1;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  out   <= acc_next;
                  Z     <= (acc_next == '0);
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/seq_wide_alu.md
SEQ_WIDE_ALU -- requirements
Module: seq_wide_alu

Interface
REQ-001 Parameter WIDTH, default 512: operand width in bits.
REQ-002 Parameter WORD, default 32: adder slice width in bits; WIDTH SHALL be a multiple of WORD, and elaboration SHALL fail otherwise.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand/op request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in1  input  WIDTH  operand A (unsigned).
REQ-008 in2  input  WIDTH  operand B (unsigned).
REQ-009 op  input  1  1 = multiply, 0 = add.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out  output  2*WIDTH  result.
REQ-013 Z  output  1  result-is-zero flag, qualified by out_valid.

Function
REQ-014 FSM states SHALL be IDLE, ADD, MUL and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: when in_valid=1, the block SHALL capture in1, in2 and op, and SHALL go to ADD (op=0) or MUL (op=1).
REQ-016 ADD SHALL process one WORD slice per cycle, LSB slice first, with the carry registered between slices, for exactly N=WIDTH/WORD cycles, then go to DONE.
REQ-017 Add result: out[WIDTH-1:0]=sum, out[WIDTH]=final carry, and out[2*WIDTH-1:WIDTH+1]=0.
REQ-018 MUL SHALL be radix-2 shift-add, one multiplier bit per cycle, LSB first, for exactly WIDTH cycles, then go to DONE; out SHALL be the full 2*WIDTH-bit product.
REQ-019 Latency from the accept edge to the first out_valid=1 cycle SHALL be N+1 cycles for add and WIDTH+1 cycles for multiply.
REQ-020 DONE: out_valid=1, and out and Z SHALL be held stable while out_ready=0; on out_ready=1 the block SHALL go to IDLE.
REQ-021 in_valid asserted outside IDLE SHALL be ignored, with no effect on the running operation.
REQ-022 Z SHALL equal 1 exactly when out==0, and SHALL be computed before DONE is entered.
REQ-023 in1, in2 and op changing after acceptance SHALL NOT affect the running result.
REQ-024 The back-to-back accept-to-accept minimum SHALL be latency + 1 cycle: one DONE cycle with out_ready=1, then IDLE.

Reset
REQ-025 While rst=1: state=IDLE, in_ready=1, out_valid=0, out=0, Z=0, and all internal accumulators and counters=0.
REQ-026 rst asserted mid-ADD, mid-MUL or in DONE SHALL abort the operation immediately; no out_valid SHALL follow for the aborted request.
REQ-027 After rst deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Structure
REQ-028 Package seq_alu_pkg SHALL hold the state enum, OP_ADD=0 / OP_MUL=1 constants, and a function computing N from WIDTH and WORD.
REQ-029 One sub-module, alu_word_adder (WORD-bit adder, carry in, carry out), SHALL be used for ADD slices.
REQ-030 The MUL accumulate path SHALL reuse alu_word_adder or use a plain WIDTH+1-bit adder.
REQ-031 The slice counter SHALL be sized $clog2(max(N, WIDTH))+1.

Verification (WIDTH=512, WORD=32)
REQ-032 Add all-ones + 1 -> out=2^512 (bit 512 set, all other bits 0), Z=0, out_valid 17 cycles after accept.
REQ-033 Add 0 + 0 -> out=0, Z=1; in_ready=0 throughout ADD.
REQ-034 Multiply all-ones x all-ones -> out=2^1024 - 2^513 + 1, Z=0, out_valid 513 cycles after accept.
REQ-035 Multiply 0x1234 x 0 -> out=0, Z=1; in_valid pulsed with op=0 mid-MUL is ignored.
REQ-036 out_ready held 0 for 10 cycles in DONE -> out and Z unchanged, then a single handshake, then in_ready=1.
REQ-037 rst pulsed at cycle 200 of a multiply -> out_valid stays 0, outputs return to reset values, and a following add 3 + 5 -> out=8.
